wcd_bus_responder: RTL

WCD_BUS_RESPONDER -- requirements
Module: wcd_bus_responder

---
 rtl/wcd_bus_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/wcd_bus_responder.sv
// wcd_bus_responder: CPU bus slave with mirrored RAM, timer/ID register bank and ROM window
module wcd_bus_responder (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] AB,
    input  logic [7:0]  DB,
    input  logic        nRD,
    input  logic        nWR,
    output logic [7:0]  DB_IN,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        irq,
    output logic        bus_err
);
    logic [7:0]  ram [0:2047];
    logic [7:0]  rld_lo, rld_hi, scratch, reg_rd;
    logic [15:0] cnt, cnt_nx;
    logic        en, irqen, auto_rl, flag;
    logic        en_nx, flag_nx;
    logic        rd, wr, clash, sel_ram, sel_reg, sel_rom, expire;

    assign rom_addr = AB[14:0];
    assign rd       = !nRD && nWR;
    assign wr       = nRD && !nWR;
    assign clash    = !nRD && !nWR;
    assign sel_ram  = AB[15:13] == 3'b000;
    assign sel_reg  = AB[15:13] == 3'b001;
    assign sel_rom  = AB[15];
    assign expire   = en && cnt == 16'h0000;

    always_comb begin
        case (AB[2:0])
            3'd0:    reg_rd = rld_lo;
            3'd1:    reg_rd = rld_hi;
            3'd2:    reg_rd = {5'd0, auto_rl, irqen, en};
            3'd3:    reg_rd = {7'd0, flag};
            3'd4:    reg_rd = cnt[7:0];
            3'd5:    reg_rd = cnt[15:8];
            3'd6:    reg_rd = scratch;
            default: reg_rd = 8'h65;
        endcase
    end

    // Bus writes are applied after the timer step so a write on an expiry edge wins,
    // except a STATUS clear, which loses to a simultaneous set.
    always_comb begin
        cnt_nx  = (en && cnt != 16'h0000) ? cnt - 16'd1 : cnt;
        en_nx   = en;
        flag_nx = flag;
        if (expire) begin
            flag_nx = 1'b1;
            if (auto_rl)
                cnt_nx = {rld_hi, rld_lo};
            else
                en_nx = 1'b0;
        end
        if (wr && sel_reg && AB[2:0] == 3'd1)
            cnt_nx = {DB, rld_lo};
        if (wr && sel_reg && AB[2:0] == 3'd2)
            en_nx = DB[0];
        if (wr && sel_reg && AB[2:0] == 3'd3 && DB[0] && !expire)
            flag_nx = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            DB_IN   <= 8'h00;
            irq     <= 1'b0;
            bus_err <= 1'b0;
            rld_lo  <= 8'h00;
            rld_hi  <= 8'h00;
            scratch <= 8'h00;
            cnt     <= 16'h0000;
            en      <= 1'b0;
            irqen   <= 1'b0;
            auto_rl <= 1'b0;
            flag    <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            en   <= en_nx;
            flag <= flag_nx;
            irq  <= flag && irqen;
            if (clash)
                bus_err <= 1'b1;
            if (rd && (sel_rom || sel_ram || sel_reg))
                DB_IN <= sel_rom ? rom_data : sel_ram ? ram[AB[10:0]] : reg_rd;
            if (wr && sel_reg) begin
                case (AB[2:0])
                    3'd0: rld_lo <= DB;
                    3'd1: rld_hi <= DB;
                    3'd2: begin
                        irqen   <= DB[1];
                        auto_rl <= DB[2];
                    end
                    3'd6: scratch <= DB;
                    default: ;
                endcase
            end
        end
    end

    // RAM has no reset; contents survive Rst.
    always_ff @(posedge Clk) begin
        if (!Rst && wr && sel_ram)
            ram[AB[10:0]] <= DB;
    end
endmodule
